alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational ALU (4-bit alu_op; 32-bit operand_a/operand_b; result, zero and overflow outputs) between two requesters.
//  Round-robin grant, valid/ready request and response handshakes, and registered operands and result.
//  Sits between two client units (e.g. address-gen and execute) and a single ALU instance outside this block.
// PARAMETERS
//  DATA_WIDTH    32  operand/result width, passed through to the ALU
//  ALU_OP_WIDTH  4   opcode width; opcodes forwarded unmodified
// PORTS
//  clk            in   1    rising-edge clock
//  rst_n          in   1    synchronous active-low reset
//  req0_valid     in   1    requester 0 has an operation
//  req0_ready     out  1    requester 0 op accepted this cycle
//  req0_a/req0_b  in   DW   requester 0 operands
//  req0_op        in   OPW  requester 0 opcode
//  req1_*         --   --   identical set for requester 1
//  rsp0_valid     out  1    result on rsp_* belongs to requester 0
//  rsp0_ready     in   1    requester 0 takes result
//  rsp1_valid     out  1    result on rsp_* belongs to requester 1
//  rsp1_ready     in   1    requester 1 takes result
//  rsp_result     out  DW   registered ALU result
//  rsp_zero       out  1    registered ALU zero flag
//  rsp_ovf        out  1    registered ALU overflow flag
//  alu_operand_a  out  DW   to ALU operand_a (registered)
//  alu_operand_b  out  DW   to ALU operand_b (registered)
//  alu_op         out  OPW  to ALU alu_op (registered)
//  alu_result     in   DW   from ALU
//  alu_zero       in   1    from ALU zero_flag
//  alu_overflow   in   1    from ALU overflow_flag
//  busy           out  1    FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (alu_op=0, rsp_*=0, valids/readys=0, busy=0); last_grant=1 so requester 0 wins first.
//  FSM IDLE -> EXEC -> RESP -> IDLE; one op per >=3 cycles.
//  IDLE:
//   - reqN_ready asserted combinationally only in IDLE, only for the granted N.
//   - Grant rules: only one valid -> that one; both valid -> requester != last_grant.
//   - On accept, capture reqN_a/b/op into alu_operand_a/b/alu_op and owner=N.
//   - Update last_grant=N; go to EXEC.
//  EXEC: ALU operands stable for the whole cycle. At the clock edge, latch alu_result/alu_zero/alu_overflow into rsp_*; go to RESP.
//  RESP:
//   - rspN_valid=1 for owner only; rsp_* held stable.
//   - Leave to IDLE on the cycle rspN_ready=1; the non-owner ready is ignored.
//   - Stalls indefinitely while rspN_ready=0.
//  No request is accepted in EXEC/RESP; requesters hold valid+data stable until ready.
//  Request accept and response return never overlap (ready only in IDLE, valid only in RESP).
//  alu_* outputs keep the last captured values outside EXEC; ALU output is sampled only in EXEC.
//  Opcodes are not decoded here. Unused opcodes (e.g. 4'b1000) pass through; the ALU returns 0.
//  rst_n low in any state, including mid-EXEC/RESP: next cycle IDLE, in-flight op discarded, rspN_valid drops, last_grant=1.
//  Valid dropped by a requester before ready: nothing accepted, no response.
// TESTING
//  T1: req0 AND, a=FFFF0000 b=00FFFF00 -> req0_ready cycle 0, rsp0_valid cycle 2, rsp_result=00FF0000, zero=0.
//  T2: req0 and req1 valid same cycle out of reset -> req0 served first; req1_ready on the first IDLE after rsp0 handshake.
//  T3: both requesters valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; no requester starved.
//  T4: req1 SUB 50-50, rsp1_ready low 5 cycles -> rsp1_valid and rsp_result=0, zero=1 stable all 5 cycles; then IDLE.
//  T5: req0 ADD 7FFFFFFF+1 -> rsp_result=80000000, rsp_ovf=1. req1 SLT FFFFFFFB,0000000A -> rsp_result=1.
//  T6: rst_n=0 for 1 cycle during EXEC -> next cycle IDLE, busy=0, no rsp valid; a new req1-only op is then accepted normally.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared external ALU.
// Operands and results are registered, and a three-state FSM allows one operation in flight.
module alu_rr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [DATA_WIDTH-1:0]   req0_a,
  input  logic [DATA_WIDTH-1:0]   req0_b,
  input  logic [ALU_OP_WIDTH-1:0] req0_op,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [DATA_WIDTH-1:0]   req1_a,
  input  logic [DATA_WIDTH-1:0]   req1_b,
  input  logic [ALU_OP_WIDTH-1:0] req1_op,
  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_ovf,
  output logic [DATA_WIDTH-1:0]   alu_operand_a,
  output logic [DATA_WIDTH-1:0]   alu_operand_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_overflow,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   owner;
  logic   grant;
  logic   grant_valid;
  logic   owner_rsp_ready;

  // On contention the requester that did not win last time takes the ALU.
  always_comb begin
    grant       = 1'b0;
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (owner_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_op        <= '0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_ovf       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_valid) begin
        owner      <= grant;
        last_grant <= grant;
        if (grant) begin
          alu_operand_a <= req1_a;
          alu_operand_b <= req1_b;
          alu_op        <= req1_op;
        end else begin
          alu_operand_a <= req0_a;
          alu_operand_b <= req0_b;
          alu_op        <= req0_op;
        end
      end
      // The ALU output is only trusted while the registered operands have been stable all cycle.
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_ovf    <= alu_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: the issuing side queues expected responses,
// and a negedge monitor tracks grant order and compares every cycle of each response.
module tb_alu_rr_arbiter;
  localparam int DW  = 32;
  localparam int OPW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          ovf;
  } rsp_t;

  logic           clk;
  logic           rst_n;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic           rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_zero, rsp_ovf;
  logic [DW-1:0]  alu_operand_a, alu_operand_b, alu_result;
  logic [OPW-1:0] alu_op;
  logic           alu_zero, alu_overflow;
  logic           busy;

  logic           drv_valid[2];
  logic [DW-1:0]  drv_a[2];
  logic [DW-1:0]  drv_b[2];
  logic [OPW-1:0] drv_op[2];
  logic           drv_rsp_ready[2];

  int   checks = 0;
  int   errors = 0;
  rsp_t q0[$];
  rsp_t q1[$];
  int   acc_cnt[2];
  int   seen_cnt[2];
  bit   random_en = 1'b0;

  int   m_state = 0;
  logic m_last = 1'b1;
  logic m_owner = 1'b0;
  logic mon_g;
  logic mon_own_rdy;
  rsp_t mon_exp;
  rsp_t alu_now;

  assign req0_valid = drv_valid[0];
  assign req0_a     = drv_a[0];
  assign req0_b     = drv_b[0];
  assign req0_op    = drv_op[0];
  assign req1_valid = drv_valid[1];
  assign req1_a     = drv_a[1];
  assign req1_b     = drv_b[1];
  assign req1_op    = drv_op[1];
  assign rsp0_ready = drv_rsp_ready[0];
  assign rsp1_ready = drv_rsp_ready[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_rr_arbiter #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .busy(busy)
  );

  // Behavioural stand-in for the external ALU; unknown opcodes return 0.
  function automatic rsp_t alu_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    rsp_t r;
    logic [DW-1:0] s;
    r = '0;
    case (op)
      OP_ADD: begin s = a + b; r.result = s; r.ovf = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]); end
      OP_SUB: begin s = a - b; r.result = s; r.ovf = (a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]); end
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_XOR: r.result = a ^ b;
      OP_SLT: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.result = '0;
    endcase
    r.zero = (r.result == '0);
    return r;
  endfunction

  always_comb alu_now = alu_ref(alu_op, alu_operand_a, alu_operand_b);
  assign alu_result   = alu_now.result;
  assign alu_zero     = alu_now.zero;
  assign alu_overflow = alu_now.ovf;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    drv_valid[n] = 1'b1;
    drv_op[n]    = op;
    drv_a[n]     = a;
    drv_b[n]     = b;
    if (n == 0) q0.push_back(alu_ref(op, a, b));
    else        q1.push_back(alu_ref(op, a, b));
  endtask

  task automatic issueRandom(input int n);
    logic [DW-1:0] a, b;
    logic [3:0] op;
    op = 4'($urandom_range(0, 8));
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    applyStimulus(n, op, a, b);
  endtask

  // Requesters drop valid once the monitor has seen their handshake.
  task automatic stepDriver();
    for (int n = 0; n < 2; n++) begin
      if (acc_cnt[n] != seen_cnt[n]) begin
        seen_cnt[n]  = acc_cnt[n];
        drv_valid[n] = 1'b0;
      end
      if (random_en) begin
        if (!drv_valid[n] && $urandom_range(0, 3) == 0) begin
          issueRandom(n);
        end else if (drv_valid[n] && $urandom_range(0, 19) == 0) begin
          drv_valid[n] = 1'b0;
          if (n == 0) void'(q0.pop_back());
          else        void'(q1.pop_back());
        end
        drv_rsp_ready[n] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic runCycles(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      stepDriver();
    end
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    drv_rsp_ready[0] = 1'b1;
    drv_rsp_ready[1] = 1'b1;
    while ((drv_valid[0] || drv_valid[1] || q0.size() != 0 || q1.size() != 0 || m_state != 0) && k < budget) begin
      runCycles(1);
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: still pending after %0d cycles, required idle", budget);
    end
  endtask

  // Reference model: grant order and response timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (m_state != 0) begin
        if (m_owner == 1'b0 && q0.size() != 0) void'(q0.pop_front());
        if (m_owner == 1'b1 && q1.size() != 0) void'(q1.pop_front());
      end
      m_state = 0;
      m_last  = 1'b1;
      m_owner = 1'b0;
    end else begin
      mon_g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      checkOutput("req0_ready", 32'(req0_ready), 32'(m_state == 0 && req0_valid && !mon_g));
      checkOutput("req1_ready", 32'(req1_ready), 32'(m_state == 0 && req1_valid && mon_g));
      checkOutput("busy", 32'(busy), 32'(m_state != 0));
      checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(m_state == 2 && !m_owner));
      checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(m_state == 2 && m_owner));
      mon_own_rdy = m_owner ? rsp1_ready : rsp0_ready;
      case (m_state)
        0: if (req0_valid || req1_valid) begin
             m_state = 1;
             m_last  = mon_g;
             m_owner = mon_g;
             acc_cnt[mon_g]++;
           end
        1: m_state = 2;
        default: begin
          if ((m_owner ? q1.size() : q0.size()) == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: response from requester %0d with no expected entry", m_owner);
          end else begin
            mon_exp = m_owner ? q1[0] : q0[0];
            checkOutput("rsp_result", rsp_result, mon_exp.result);
            checkOutput("rsp_zero", 32'(rsp_zero), 32'(mon_exp.zero));
            checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(mon_exp.ovf));
            if (mon_own_rdy) begin
              if (m_owner) void'(q1.pop_front());
              else         void'(q0.pop_front());
            end
          end
          if (mon_own_rdy) m_state = 0;
        end
      endcase
    end
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int k;
    for (int n = 0; n < 2; n++) begin
      drv_valid[n] = 1'b0; drv_a[n] = '0; drv_b[n] = '0; drv_op[n] = '0;
      drv_rsp_ready[n] = 1'b0; acc_cnt[n] = 0; seen_cnt[n] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    checkOutput("rst_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
    checkOutput("rst_rsp_result", rsp_result, 32'd0);
    checkOutput("rst_flags", 32'({rsp_zero, rsp_ovf}), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_a", alu_operand_a, 32'd0);

    $display("[TB] simultaneous requests out of reset, AND on req0");
    drv_rsp_ready[0] = 1'b1;
    drv_rsp_ready[1] = 1'b1;
    applyStimulus(0, OP_AND, 32'hFFFF0000, 32'h00FFFF00);
    applyStimulus(1, OP_OR, 32'h0000000F, 32'h000000F0);
    waitDrain(40);

    $display("[TB] continuous contention alternates grants");
    for (int i = 0; i < 20; i++) begin
      if (!drv_valid[0]) issueRandom(0);
      if (!drv_valid[1]) issueRandom(1);
      runCycles(1);
    end
    waitDrain(40);

    $display("[TB] response stall on req1");
    drv_rsp_ready[1] = 1'b0;
    applyStimulus(1, OP_SUB, 32'd50, 32'd50);
    runCycles(7);
    waitDrain(40);

    $display("[TB] overflow, signed compare and unused opcode");
    applyStimulus(0, OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    applyStimulus(1, OP_SLT, 32'hFFFFFFFB, 32'h0000000A);
    waitDrain(40);
    applyStimulus(0, 4'b1000, 32'h12345678, 32'h9ABCDEF0);
    waitDrain(40);

    $display("[TB] randomized traffic");
    random_en = 1'b1;
    runCycles(400);
    random_en = 1'b0;
    waitDrain(100);

    $display("[TB] reset during EXEC");
    applyStimulus(0, OP_ADD, 32'd3, 32'd4);
    k = 0;
    while (m_state != 1 && k < 10) begin
      runCycles(1);
      k++;
    end
    checkOutput("exec_reached", 32'(m_state == 1), 32'd1);
    rst_n = 1'b0;
    runCycles(1);
    rst_n = 1'b1;
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    applyStimulus(1, OP_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F);
    waitDrain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
